// File: rtl/stall_flush_ctrl.sv
// Pipeline hold/bubble/flush vector generator for NREQ tagged stall requesters (level or self-timed).
// Outputs are combinational, same cycle as request; no backpressure, flush always overrides hold.
module stall_flush_ctrl #(
   parameter int STAGES = 6,
   parameter int NREQ   = 4,
   parameter int SW     = 3,
   parameter int CNT_W  = 4,
   parameter int PERF_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*SW-1:0]    req_stage,
   input  logic [NREQ*CNT_W-1:0] req_cycles,
   input  logic                  flush,
   input  logic [SW-1:0]         flush_stage,
   output logic [STAGES-1:0]     stall,
   output logic [STAGES-1:0]     bubble,
   output logic [STAGES-1:0]     flush_o,
   output logic                  pending,
   output logic [PERF_W-1:0]     stall_cycles
);

   logic [CNT_W-1:0] cnt     [NREQ];
   logic [SW-1:0]    stg     [NREQ];
   logic [SW-1:0]    cur_stg [NREQ];
   logic [NREQ-1:0]  busy;
   logic [NREQ-1:0]  act;
   logic [NREQ-1:0]  cancel;
   logic [NREQ-1:0]  load;

   always_comb begin
      int fs;
      int kmax;
      fs   = (int'(flush_stage) >= STAGES) ? STAGES - 1 : int'(flush_stage);
      kmax = -1;
      for (int i = 0; i < NREQ; i++) begin
         busy[i]    = (cnt[i] != '0);
         act[i]     = req_valid[i] | busy[i];
         cur_stg[i] = busy[i] ? stg[i] : req_stage[i*SW +: SW];
         cancel[i]  = flush & act[i] & (int'(cur_stg[i]) <= fs);
         load[i]    = req_valid[i] & ~busy[i] & ~cancel[i] &
                      (req_cycles[i*CNT_W +: CNT_W] != '0);
         if (act[i] && !cancel[i] && int'(cur_stg[i]) > kmax)
            kmax = int'(cur_stg[i]);
      end
      // Hold everything up to the oldest blocked stage, inject a NOP just behind it,
      // then let the squash window override both.
      for (int k = 0; k < STAGES; k++) begin
         flush_o[k] = rst & flush & (k <= fs);
         stall[k]   = rst & (k <= kmax) & ~flush_o[k];
         bubble[k]  = rst & (kmax >= 0) & (k == kmax + 1) & ~flush_o[k];
      end
      pending = rst & (|busy);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREQ; i++) begin
            cnt[i] <= '0;
            stg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (cancel[i]) begin
               cnt[i] <= '0;
            end else if (busy[i]) begin
               cnt[i] <= cnt[i] - CNT_W'(1);
            end else if (load[i]) begin
               cnt[i] <= req_cycles[i*CNT_W +: CNT_W] - CNT_W'(1);
               stg[i] <= req_stage[i*SW +: SW];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cycles <= '0;
      else if (|stall)
         stall_cycles <= stall_cycles + PERF_W'(1);
   end

endmodule
